// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and sizing helpers for the async FIFO read/write packers.
//   pack_state_e : packer FSM states (FILL accumulates beats, HOLD presents a
//                  packed word downstream)
//   out_w()      : packed word width = entry width * entries per word
//   cnt_w()      : beat counter width, able to hold 0..PACK_RATIO
//   tmr_w()      : idle timer width, able to hold 0..TIMEOUT (min 1 bit)
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK_RATIO = 4;
  localparam int DEF_TIMEOUT    = 16;

  function automatic int out_w(input int data_width, input int pack_ratio);
    return data_width * pack_ratio;
  endfunction

  function automatic int cnt_w(input int pack_ratio);
    return $clog2(pack_ratio + 1);
  endfunction

  // A disabled timeout (0) still needs a legal 1-bit counter.
  function automatic int tmr_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fifo_idle_timer.sv
// ---------------------------------------------------------------------------
// fifo_idle_timer
// Saturating idle counter shared by the FIFO packers.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one idle cycle
//   hit        : this edge's increment reaches (or sits at) MAX; the owner
//                acts on the same edge the counter reaches MAX.
// MAX = 0 disables the timer: hit is then constantly 0.
// ---------------------------------------------------------------------------
module fifo_idle_timer #(
  parameter int WIDTH = 5,
  parameter int MAX   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'((MAX > 0) ? MAX - 1 : 0);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != MAX_V)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign hit = (MAX != 0) && en && !clr && (count_q >= MAX_M1);

endmodule

// File: rtl/fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// fifo_rd_packer
// Read-side consumer of the async FIFO (rclk domain). Pops DATA_WIDTH-bit
// entries and packs PACK_RATIO of them into one word, beat 0 in the LSBs.
// Partial words leave on flush or after TIMEOUT idle cycles (0 = never).
//   rclk, rrst_n : read clock, asynchronous active-low reset
//   rdata        : FIFO head entry, valid while rempty = 0
//   rempty       : FIFO empty flag
//   rinc         : pop strobe to the FIFO (combinational)
//   flush        : single-cycle request to emit a pending partial word
//   out_data     : packed word; lanes at or above out_count read as 0
//   out_count    : valid beats in out_data, 1..PACK_RATIO while out_valid
//   out_valid    : packed word available (registered)
//   out_ready    : downstream accepts the word
// ---------------------------------------------------------------------------
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK_RATIO = DEF_PACK_RATIO,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                                 rclk,
  input  logic                                 rrst_n,
  input  logic [DATA_WIDTH-1:0]                rdata,
  input  logic                                 rempty,
  output logic                                 rinc,
  input  logic                                 flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0]     out_data,
  output logic [$clog2(PACK_RATIO+1)-1:0]      out_count,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int OUT_W = out_w(DATA_WIDTH, PACK_RATIO);
  localparam int CNT_W = cnt_w(PACK_RATIO);
  localparam int TMR_W = tmr_w(TIMEOUT);
  localparam int IDX_W = $clog2(PACK_RATIO);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PACK_RATIO - 1);

  pack_state_e                            state_q, state_d;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]  lane_q;
  logic [CNT_W-1:0]                       count_q;

  logic pop;
  logic accept;
  logic full_emit;
  logic flush_emit;
  logic timeout_emit;
  logic tmr_clr;
  logic tmr_en;

  // rinc is gated by reset so the FIFO is never popped while the packer is
  // being cleared, even if the FIFO side is not in reset.
  assign pop    = rrst_n && (state_q == FILL) && !rempty;
  assign accept = (state_q == HOLD) && out_ready;

  // A pop completing the word, or a flush with at least one beat after this
  // edge (a coincident pop counts), moves the word to HOLD.
  assign full_emit  = pop && (count_q == LAST_BEAT);
  assign flush_emit = flush && ((count_q != '0) || pop);

  // The timer only runs while a partial word sits idle in FILL; in HOLD it
  // neither counts nor clears, and leaving HOLD clears it.
  assign tmr_clr = pop || accept || (count_q == '0);
  assign tmr_en  = (state_q == FILL) && (count_q != '0) && !pop;

  fifo_idle_timer #(
    .WIDTH (TMR_W),
    .MAX   (TIMEOUT)
  ) u_idle_timer (
    .clk   (rclk),
    .rst_n (rrst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .hit   (timeout_emit)
  );

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (full_emit || flush_emit || timeout_emit) state_d = HOLD;
      HOLD: if (out_ready)                              state_d = FILL;
      default:                                          state_d = FILL;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state_q <= FILL;
    else         state_q <= state_d;
  end

  // NOTE: the lane register is reset (unlike a plain storage array) because
  // out_data must read 0 after reset and unused lanes must read 0.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      lane_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      lane_q  <= '0;
      count_q <= '0;
    end else if (pop) begin
      lane_q[count_q[IDX_W-1:0]] <= rdata;
      count_q                    <= count_q + 1'b1;
    end
  end

  assign rinc      = pop;
  assign out_data  = OUT_W'(lane_q);
  assign out_count = count_q;
  assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_packer
// Self-checking bench: a queue-based FIFO and packer model is advanced once
// per cycle and compared with the DUT on the falling edge; directed scenarios
// pin the model with literal words. A second instance covers TIMEOUT = 0.
// ---------------------------------------------------------------------------
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int TO = 16;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic [7:0]  rdata;
  logic        rempty, rinc, flush, out_valid, out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  logic [7:0]  nt_rdata;
  logic        nt_rempty, nt_rinc, nt_flush, nt_valid, nt_ready;
  logic [31:0] nt_data;
  logic [2:0]  nt_count;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT(TO)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .flush(flush), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT(0)) dut_nt (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(nt_rdata), .rempty(nt_rempty), .rinc(nt_rinc),
    .flush(nt_flush), .out_data(nt_data), .out_count(nt_count),
    .out_valid(nt_valid), .out_ready(nt_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: FIFO contents, beats collected so far, whether a word is held,
  // and idle cycles since the last pop (saturating at TO).
  logic [7:0] fifo_q[$];
  logic [7:0] m_beats[$];
  bit         m_hold = 0;
  int         m_idle = 0;

  int          pops = 0, handshakes = 0, valid_cycles = 0;
  logic [31:0] last_data = '0;
  logic [2:0]  last_count = '0;
  logic        last_rinc = 0, last_valid = 0;

  function automatic logic [31:0] m_word();
    logic [31:0] w = '0;
    foreach (m_beats[i]) w[i*8 +: 8] = m_beats[i];
    return w;
  endfunction

  task automatic step(input bit fl, input bit rdy, input bit gap);
    bit pop_e;
    rempty    = gap || (fifo_q.size() == 0);
    rdata     = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    flush     = fl;
    out_ready = rdy;
    @(negedge rclk);
    pop_e = !m_hold && !rempty;
    check("rinc", rinc, pop_e);
    check("out_valid", out_valid, m_hold);
    if (m_hold) begin
      check("out_data", out_data, m_word());
      check("out_count", out_count, m_beats.size());
    end
    last_rinc  = rinc;
    last_valid = out_valid;
    if (out_valid) begin
      last_data  = out_data;
      last_count = out_count;
      valid_cycles++;
      if (out_ready) handshakes++;
    end
    if (rinc) pops++;
    @(posedge rclk);
    #1;
    if (m_hold) begin
      if (rdy) begin
        m_hold = 0;
        m_beats.delete();
        m_idle = 0;
      end
    end else begin
      if (pop_e) begin
        m_beats.push_back(fifo_q.pop_front());
        m_idle = 0;
      end else if (m_beats.size() != 0 && m_idle < TO) begin
        m_idle++;
      end
      if (m_beats.size() == PR || (fl && m_beats.size() != 0) ||
          (TO != 0 && !pop_e && m_beats.size() != 0 && m_idle >= TO))
        m_hold = 1;
    end
  endtask

  // Asserts reset between clock edges, checks outputs clear at once, then
  // releases on a falling edge with the FIFO empty.
  task automatic async_reset(input string tag);
    #2;
    rempty = 1'b0;
    rdata  = 8'hEE;
    rrst_n = 1'b0;
    #1;
    check({tag, "_rinc"}, rinc, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_count"}, out_count, 0);
    m_hold = 0;
    m_beats.delete();
    m_idle = 0;
    fifo_q.delete();
    rempty = 1'b1;
    @(negedge rclk);
    rrst_n = 1'b1;
    @(posedge rclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, hs0, vc0, nt_vc;
    rempty = 1'b1; rdata = '0; flush = 0; out_ready = 0;
    nt_rempty = 1'b1; nt_rdata = '0; nt_flush = 0; nt_ready = 0;

    // Reset state, with the FIFO reporting data to prove rinc is gated.
    #12;
    rempty = 1'b0;
    #1;
    check("reset_rinc", rinc, 0);
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_count", out_count, 0);
    rempty = 1'b1;
    @(negedge rclk);
    rrst_n = 1'b1;
    @(posedge rclk);
    #1;

    // Full word with out_ready held high.
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    pops = 0; handshakes = 0; valid_cycles = 0;
    repeat (8) step(0, 1, 0);
    check("full_pops", pops, 4);
    check("full_words", handshakes, 1);
    check("full_valid_cycles", valid_cycles, 1);
    check("full_data", last_data, 32'h44332211);
    check("full_count", last_count, 4);

    // Backpressure: word held for 10 cycles, then one-cycle bubble.
    fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    pops = 0;
    repeat (4) step(0, 0, 0);
    fifo_q.push_back(8'h07);
    fifo_q.push_back(8'h08);
    repeat (10) step(0, 0, 0);
    check("bp_hold_pops", pops, 4);
    check("bp_hold_data", last_data, 32'h04030201);
    step(0, 1, 0);
    check("bp_handshake_rinc", last_rinc, 0);
    pops = 0;
    step(0, 0, 0);
    check("bp_first_pop", last_rinc, 1);
    repeat (4) step(0, 0, 0);
    check("bp_next_pops", pops, 4);
    check("bp_next_data", last_data, 32'h08070605);
    step(0, 1, 0);
    step(0, 0, 0);

    // Explicit flush, then a flush with nothing pending.
    fifo_q = '{8'hAA, 8'hBB};
    repeat (2) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    check("flush_data", last_data, 32'h0000BBAA);
    check("flush_count", last_count, 2);
    hs0 = handshakes; vc0 = valid_cycles;
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);
    check("flush_empty_words", valid_cycles - vc0, 0);
    check("flush_empty_hs", handshakes - hs0, 0);

    // Idle timeout after a single beat.
    fifo_q = '{8'h5C};
    step(0, 0, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0);
      if (last_valid) break;
      n++;
    end
    check("timeout_idle_cycles", n, TO);
    check("timeout_count", last_count, 1);
    check("timeout_data", last_data, 32'h0000005C);
    step(0, 1, 0);

    // Flush coincident with a pop.
    fifo_q = '{8'h01, 8'h02};
    repeat (2) step(0, 0, 0);
    fifo_q.push_back(8'h7E);
    step(1, 0, 0);
    step(0, 1, 0);
    check("flushpop_count", last_count, 3);
    check("flushpop_lane2", last_data[23:16], 8'h7E);
    check("flushpop_data", last_data, 32'h007E0201);

    // Reset with a partial word, then with a held word.
    fifo_q = '{8'hA1, 8'hA2, 8'hA3};
    repeat (3) step(0, 0, 0);
    async_reset("rst_fill");
    fifo_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    repeat (6) step(0, 1, 0);
    check("rst_fill_next", last_data, 32'hB4B3B2B1);
    fifo_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    repeat (5) step(0, 0, 0);
    check("rst_hold_valid", last_valid, 1);
    async_reset("rst_hold");
    fifo_q = '{8'hD1, 8'hD2};
    repeat (2) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    check("rst_hold_next", last_data, 32'h0000D2D1);
    check("rst_hold_count", last_count, 2);

    // Randomized traffic: bursty FIFO, random flush and backpressure.
    repeat (600) begin
      if ($urandom_range(2) == 0 && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
      step($urandom_range(7) == 0, 1'($urandom), $urandom_range(3) == 0);
    end
    repeat (24) step(1, 1, 0);

    // TIMEOUT = 0 instance: a lone beat is never auto-emitted.
    nt_ready  = 1'b0;
    nt_rempty = 1'b0;
    nt_rdata  = 8'h5C;
    step(0, 1, 1);
    nt_rempty = 1'b1;
    nt_vc = 0;
    repeat (40) begin
      step(0, 1, 1);
      if (nt_valid) nt_vc++;
    end
    check("nt_no_timeout", nt_vc, 0);
    nt_flush = 1'b1;
    step(0, 1, 1);
    nt_flush = 1'b0;
    check("nt_flush_valid", nt_valid, 1);
    check("nt_flush_count", nt_count, 1);
    check("nt_flush_data", nt_data, 32'h0000005C);
    nt_ready = 1'b1;
    step(0, 1, 1);
    check("nt_released", nt_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
